// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// State encoding is also consumed by the display and stall logic.
package dmem_port_arbiter_pkg;

  localparam int AW_DEF  = 10;
  localparam int DW_DEF  = 32;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_STALL = 2'd1,
    ARB_STEAL = 2'd2,
    ARB_DATA  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating count of consecutive blocked debug cycles.
// hit flags the cycle whose edge brings the count to MAX.
module dmem_port_arbiter_starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic btnclk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge btnclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = inc && (cnt >= CNT_W'(MAX - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares Data_Mem between the MEM stage and a debug read port.
// Pipeline has priority; a starved debug read freezes it for one access.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          btnclk,
  input  logic          rst,
  input  logic          pipe_wr,
  input  logic          pipe_rd,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic [DW-1:0] pipe_rdata,
  output logic          pipe_stall_req,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_valid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta
);

  arb_state_t    state, state_nx;
  logic          pipe_act;
  logic          in_idle;
  logic          grant_idle;
  logic          blocked;
  logic          cnt_clr;
  logic          cnt_hit;
  logic [AW-1:0] dbg_addr_q;

  assign pipe_act   = pipe_wr | pipe_rd;
  assign in_idle    = (state == ARB_IDLE);
  assign grant_idle = in_idle && dbg_req && !pipe_act;
  assign blocked    = in_idle && dbg_req && pipe_act;
  assign cnt_clr    = (in_idle && !dbg_req) || grant_idle
                   || (state == ARB_STEAL);
  assign pipe_rdata = mem_douta;

  dmem_port_arbiter_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .btnclk (btnclk),
    .rst    (rst),
    .inc    (blocked),
    .clr    (cnt_clr),
    .hit    (cnt_hit)
  );

  always_ff @(posedge btnclk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (grant_idle)   state_nx = ARB_DATA;
        else if (cnt_hit) state_nx = ARB_STALL;
      end
      ARB_STALL: state_nx = ARB_STEAL;
      ARB_STEAL: state_nx = ARB_DATA;
      ARB_DATA:  state_nx = ARB_IDLE;
    endcase
  end

  // Pipeline access is masked in STALL; it is re-presented after release.
  always_comb begin
    dbg_gnt   = 1'b0;
    mem_addra = pipe_addr;
    mem_wea   = 1'b0;
    mem_dina  = pipe_wdata;
    if (!rst) begin
      unique case (1'b1)
        (state == ARB_STEAL): begin
          dbg_gnt   = 1'b1;
          mem_addra = dbg_addr_q;
        end
        grant_idle: begin
          dbg_gnt   = 1'b1;
          mem_addra = dbg_addr;
        end
        (state == ARB_STALL): ;
        default: mem_wea = pipe_wr;
      endcase
    end
  end

  always_ff @(posedge btnclk or posedge rst) begin
    if (rst) begin
      dbg_addr_q     <= '0;
      pipe_stall_req <= 1'b0;
      dbg_valid      <= 1'b0;
      dbg_rdata      <= '0;
    end else begin
      if (in_idle && dbg_req) dbg_addr_q <= dbg_addr;
      pipe_stall_req <= (state_nx == ARB_STALL)
                     || (state_nx == ARB_STEAL);
      dbg_valid      <= (state == ARB_DATA);
      if (state == ARB_DATA) dbg_rdata <= mem_douta;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter with a behavioural read-first Data_Mem.
// Debug read results are scoreboarded and checked on dbg_valid.
module tb_dmem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          btnclk = 1'b0;
  logic          rst;
  logic          pipe_wr, pipe_rd;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic          pipe_stall_req;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt, dbg_valid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina, mem_douta;

  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] expmem [0:1023];
  logic [DW-1:0] sb [$];

  int n_vec   = 0;
  int n_err   = 0;
  int n_stall = 0;
  int n_wea   = 0;
  int n_valid = 0;

  dmem_port_arbiter #(
    .AW (AW), .DW (DW), .STARVE_MAX (4)
  ) dut (
    .btnclk         (btnclk),
    .rst            (rst),
    .pipe_wr        (pipe_wr),
    .pipe_rd        (pipe_rd),
    .pipe_addr      (pipe_addr),
    .pipe_wdata     (pipe_wdata),
    .pipe_rdata     (pipe_rdata),
    .pipe_stall_req (pipe_stall_req),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_gnt        (dbg_gnt),
    .dbg_valid      (dbg_valid),
    .dbg_rdata      (dbg_rdata),
    .mem_wea        (mem_wea),
    .mem_addra      (mem_addra),
    .mem_dina       (mem_dina),
    .mem_douta      (mem_douta)
  );

  always #5 btnclk = ~btnclk;

  always @(posedge btnclk) begin
    if (mem_wea) mem[mem_addra] <= mem_dina;
    mem_douta <= mem[mem_addra];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge btnclk) begin
    if (pipe_stall_req) n_stall++;
    if (mem_wea) n_wea++;
    if (dbg_valid) begin
      n_valid++;
      if (sb.size() == 0)
        chk("spurious_valid", 32'(dbg_valid), 32'd0);
      else
        chk("dbg_rdata", dbg_rdata, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge btnclk);
    #1;
  endtask

  task automatic st(input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    pipe_wr    = 1'b1;
    pipe_addr  = a;
    pipe_wdata = d;
    expmem[a]  = d;
    tick();
    pipe_wr    = 1'b0;
  endtask

  task automatic dbg_read_idle(input logic [AW-1:0] a);
    dbg_req  = 1'b1;
    dbg_addr = a;
    sb.push_back(expmem[a]);
    #1;
    chk("gnt_c0", 32'(dbg_gnt), 32'd1);
    tick();
    chk("gnt_c1", 32'(dbg_gnt), 32'd0);
    chk("valid_c1", 32'(dbg_valid), 32'd0);
    tick();
    chk("valid_c2", 32'(dbg_valid), 32'd1);
    dbg_req = 1'b0;
  endtask

  initial begin
    int ns0, nw0, nv0, k, guard;
    logic hold;
    rst = 1'b1;
    pipe_wr = 1'b1; pipe_rd = 1'b0;
    pipe_addr = 10'd1; pipe_wdata = 32'h1111_1111;
    dbg_req = 1'b1; dbg_addr = 10'd2;
    #2;
    chk("rst_stall", 32'(pipe_stall_req), 32'd0);
    chk("rst_valid", 32'(dbg_valid), 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_gnt", 32'(dbg_gnt), 32'd0);
    chk("rst_wea", 32'(mem_wea), 32'd0);
    tick();
    tick();
    rst = 1'b0; pipe_wr = 1'b0; dbg_req = 1'b0;
    tick();

    st(10'd5, 32'hDEAD_BEEF);
    st(10'd7, 32'hCAFE_F00D);
    st(10'd9, 32'h0BAD_F00D);

    // unblocked read
    ns0 = n_stall;
    dbg_read_idle(10'd5);
    tick();
    chk("t1_no_stall", 32'(n_stall - ns0), 32'd0);

    // read right after a store to the same word
    st(10'd3, 32'h1234_5678);
    dbg_read_idle(10'd3);
    tick();

    // starvation under continuous loads
    ns0 = n_stall;
    pipe_rd = 1'b1; pipe_addr = 10'd20;
    dbg_req = 1'b1; dbg_addr = 10'd7;
    sb.push_back(expmem[7]);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_pre_stall", 32'(pipe_stall_req), 32'd0);
    end
    tick();
    chk("t3_stall_rise", 32'(pipe_stall_req), 32'd1);
    chk("t3_stall_wea", 32'(mem_wea), 32'd0);
    chk("t3_stall_gnt", 32'(dbg_gnt), 32'd0);
    tick();
    chk("t3_steal_stall", 32'(pipe_stall_req), 32'd1);
    chk("t3_steal_gnt", 32'(dbg_gnt), 32'd1);
    chk("t3_steal_addr", 32'(mem_addra), 32'd7);
    chk("t3_steal_wea", 32'(mem_wea), 32'd0);
    tick();
    chk("t3_data_stall", 32'(pipe_stall_req), 32'd0);
    chk("t3_data_valid", 32'(dbg_valid), 32'd0);
    tick();
    chk("t3_valid", 32'(dbg_valid), 32'd1);
    dbg_req = 1'b0; pipe_rd = 1'b0;
    chk("t3_stall_len", 32'(n_stall - ns0), 32'd2);
    tick();

    // stores advancing like a pipeline, frozen while stall is high
    nw0 = n_wea;
    dbg_req = 1'b1; dbg_addr = 10'd9;
    sb.push_back(expmem[9]);
    k = 0; guard = 0;
    while (k < 5 && guard < 12) begin
      pipe_wr    = 1'b1;
      pipe_addr  = AW'(40 + k);
      pipe_wdata = 32'h100 + 32'(k);
      expmem[40 + k] = pipe_wdata;
      hold = pipe_stall_req;
      tick();
      if (!hold) k++;
      guard++;
    end
    pipe_wr = 1'b0;
    chk("t4_freeze_done", 32'(k), 32'd5);
    chk("t4_valid", 32'(dbg_valid), 32'd1);
    dbg_req = 1'b0;
    chk("t4_wea_cnt", 32'(n_wea - nw0), 32'd5);
    for (int j = 0; j < 5; j++)
      chk("t4_mem", mem[40 + j], 32'h100 + 32'(j));
    tick();

    // load in DATA, back-to-back request, address change after grant
    dbg_req = 1'b1; dbg_addr = 10'd5;
    sb.push_back(expmem[5]);
    #1;
    chk("t5_gnt", 32'(dbg_gnt), 32'd1);
    tick();
    pipe_rd = 1'b1; pipe_addr = 10'd3;
    dbg_addr = 10'd11;
    tick();
    chk("t5_pipe_rdata", pipe_rdata, expmem[3]);
    chk("t5_valid", 32'(dbg_valid), 32'd1);
    pipe_rd = 1'b0;
    dbg_addr = 10'd9;
    sb.push_back(expmem[9]);
    #1;
    chk("t5_b2b_gnt", 32'(dbg_gnt), 32'd1);
    tick();
    dbg_addr = 10'd3;
    tick();
    chk("t5_b2b_valid", 32'(dbg_valid), 32'd1);
    dbg_req = 1'b0;
    tick();

    // reset during STALL
    pipe_rd = 1'b1; pipe_addr = 10'd20;
    dbg_req = 1'b1; dbg_addr = 10'd7;
    repeat (4) tick();
    chk("t6_in_stall", 32'(pipe_stall_req), 32'd1);
    nv0 = n_valid;
    pipe_wr = 1'b1; pipe_addr = 10'd50; pipe_wdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", 32'(pipe_stall_req), 32'd0);
    chk("t6_rst_gnt", 32'(dbg_gnt), 32'd0);
    chk("t6_rst_valid", 32'(dbg_valid), 32'd0);
    chk("t6_rst_rdata", dbg_rdata, 32'd0);
    chk("t6_rst_wea", 32'(mem_wea), 32'd0);
    tick();
    rst = 1'b0; pipe_wr = 1'b0; pipe_rd = 1'b0; dbg_req = 1'b0;
    repeat (3) tick();
    chk("t6_no_valid", 32'(n_valid - nv0), 32'd0);
    dbg_read_idle(10'd7);
    repeat (2) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port synchronous data memory (Data_Mem) between two requesters: the pipeline MEM stage and a debug read port.
- The debug read port lets the LCD/display logic inspect data-memory words selected by the switches.
- The pipeline has fixed priority. Debug reads use idle memory cycles.
- When the debug port is starved, the block requests a one-access pipeline freeze and steals the port.
- Sits between the EX/MEM register outputs and Data_Mem, clocked by btnclk.

Parameters:
- AW, 10, word-address width (memory byte address bits [11:2]).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive blocked debug cycles before a stall is requested; legal range 1..15.

Ports:
- btnclk  in  1  system clock (debounced step clock).
- rst  in  1  reset.
- pipe_wr  in  1  MEM-stage store (me_WMEM).
- pipe_rd  in  1  MEM-stage load (me_LW).
- pipe_addr  in  AW  MEM-stage word address.
- pipe_wdata  in  DW  store data.
- pipe_rdata  out  DW  load data; equals mem_douta.
- pipe_stall_req  out  1  freeze request to the stall network.
- dbg_req  in  1  debug read request; level, held until dbg_valid.
- dbg_addr  in  AW  debug word address.
- dbg_gnt  out  1  debug address accepted this cycle.
- dbg_valid  out  1  one-cycle pulse; dbg_rdata is valid.
- dbg_rdata  out  DW  registered debug read data.
- mem_wea  out  1  to Data_Mem.
- mem_addra  out  AW  to Data_Mem.
- mem_dina  out  DW  to Data_Mem.
- mem_douta  in  DW  from Data_Mem; 1-cycle read latency, read-first.

Behaviour:
- Reset is rst, asynchronous, active-high; the clock is btnclk.
- Reset values: state IDLE; starve counter 0; pipe_stall_req 0; dbg_valid 0; dbg_rdata 0; dbg_gnt 0. While rst is high, mem_wea is forced to 0.
- pipe_act = pipe_wr | pipe_rd.
- Port mux (combinational):
  - In state STEAL: address = latched debug address; mem_wea = 0.
  - Else, when dbg_gnt = 1: address = dbg_addr; mem_wea = 0.
  - Otherwise: address = pipe_addr; mem_wea = pipe_wr; mem_dina = pipe_wdata.
- States:
  - IDLE:
    - dbg_req & ~pipe_act: dbg_gnt = 1, latch dbg_addr, go to DATA.
    - dbg_req & pipe_act: counter += 1 (saturating at 15). When the counter reaches STARVE_MAX at a clock edge, set pipe_stall_req = 1 and go to STALL.
  - STALL: the pipeline is frozen this cycle and its access is masked (mem_wea = 0, the arbiter ignores pipe_*). Go to STEAL.
  - STEAL: present the latched address, dbg_gnt = 1, clear the counter. pipe_stall_req stays 1 through this cycle and drops at the edge. Go to DATA.
  - DATA: mem_douta holds the debug word. At the edge, dbg_rdata <= mem_douta, dbg_valid = 1 next cycle, state -> IDLE. Pipeline accesses in DATA are served normally and are not blocked.
- Latency:
  - Unblocked debug read: grant cycle N, dbg_valid in cycle N+2.
  - Starved debug read: dbg_valid 3 cycles after the threshold edge.
- Freeze contract: the pipeline holds all stage registers while pipe_stall_req = 1. The masked MEM access therefore re-presents after release and is executed once. No store is lost or duplicated.
- Counter: clears on grant, and in IDLE when dbg_req is low.
- Back-to-back: dbg_req held high after dbg_valid starts a new request in IDLE the following cycle.
- dbg_req dropped mid-transaction: the transaction completes and dbg_valid still pulses. The requester ignores it.
- Same address: a debug read granted the cycle after a pipeline store to the same address returns the new data.
- dbg_addr changing after grant has no effect on the transaction in flight.
- Reset asserted mid-transaction: immediate return to the reset values. No dbg_valid is produced.

Decomposition:
- Shared package: state encoding constants (IDLE, STALL, STEAL, DATA) and the AW/DW defaults, reused by the display and stall logic.
- Sub-module starve_counter (saturating counter with threshold compare) is natural. Everything else stays in the arbiter.

Test Plan:
- Idle memory, word 5 preloaded 0xDEADBEEF; dbg_req with dbg_addr = 5 -> dbg_gnt in cycle 0, dbg_valid and dbg_rdata = 0xDEADBEEF in cycle 2, pipe_stall_req never asserted.
- pipe_wr to address 3 with 0x12345678, debug read of address 3 the next cycle -> dbg_rdata = 0x12345678.
- pipe_rd held high continuously, dbg_req to address 7 -> pipe_stall_req rises after 4 blocked cycles, stays high exactly 2 cycles, dbg_valid with mem[7] follows, and mem_wea = 0 during STALL/STEAL.
- A store held at the MEM stage during a freeze -> the write occurs exactly once, after release (check mem contents and the count of mem_wea pulses).
- pipe_rd issued in the DATA cycle -> pipeline load data correct next cycle and debug data also correct.
- rst asserted during STALL -> all outputs 0 and state IDLE immediately; no dbg_valid; a debug read after release completes normally.
